// File: rtl/t_mod_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : t_mod_counter_if
//  Purpose  : Control/status bundle for the modulus T-flip-flop counter.
//             The master drives the count controls; the slave (the counter)
//             returns state, terminal count and the one-cycle status pulses.
//  Revision : 1.0  initial release
// ============================================================================
interface t_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             load_err;
    logic [WIDTH-1:0] toggles;

    modport master (
        output en, up, load, din,
        input  q, tc, wrap, load_err, toggles
    );

    modport slave (
        input  en, up, load, din,
        output q, tc, wrap, load_err, toggles
    );
endinterface
`default_nettype wire

// File: rtl/t_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : t_mod_counter
//  Purpose  : Modulus counter built from a bank of T flip-flops. Supports
//             up/down counting, parallel load with range saturation, enable,
//             cascade terminal count, wrap flag and a selectable clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module t_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int NEG_EDGE = 1
) (
    input  wire                    clk,
    input  wire                    rst,
    t_mod_counter_if.slave         bus
);

    // Reject parameter sets the counter cannot represent.
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("t_mod_counter: WIDTH must be >= 1");
        end
        if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("t_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    // One extra bit keeps MODULUS == 2**WIDTH representable in compares.
    localparam logic [WIDTH:0]   c_mod      = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   c_last_ext = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_last     = c_last_ext[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero     = '0;

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_load_err;
    logic [WIDTH-1:0] r_toggles;

    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_toggle_mask;
    logic             w_wrap_next;
    logic             w_load_err_next;
    logic             w_at_last;
    logic             w_at_zero;

    assign w_at_last = ({1'b0, r_q} == c_last_ext);
    assign w_at_zero = (r_q == c_zero);

    // Next-state selection: load beats enable; wrap/load_err default low so
    // each pulse lasts exactly one active edge.
    always_comb begin
        w_q_next        = r_q;
        w_wrap_next     = 1'b0;
        w_load_err_next = 1'b0;
        if (bus.load) begin
            if ({1'b0, bus.din} < c_mod) begin
                w_q_next = bus.din;
            end else begin
                w_q_next        = c_last;
                w_load_err_next = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                if (w_at_last) begin
                    w_q_next    = c_zero;
                    w_wrap_next = 1'b1;
                end else begin
                    w_q_next = r_q + c_one;
                end
            end else begin
                if (w_at_zero) begin
                    w_q_next    = c_last;
                    w_wrap_next = 1'b1;
                end else begin
                    w_q_next = r_q - c_one;
                end
            end
        end
    end

    // The T flip-flop bank toggles exactly the bits that differ.
    assign w_toggle_mask = r_q ^ w_q_next;

    // State register on the selected clock edge with asynchronous reset.
    generate
        if (NEG_EDGE != 0) begin : g_neg_edge
            // Falling-edge T flip-flop bank and status pulses.
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    r_q        <= '0;
                    r_wrap     <= 1'b0;
                    r_load_err <= 1'b0;
                    r_toggles  <= '0;
                end else begin
                    r_q        <= r_q ^ w_toggle_mask;
                    r_wrap     <= w_wrap_next;
                    r_load_err <= w_load_err_next;
                    r_toggles  <= w_toggle_mask;
                end
            end
        end else begin : g_pos_edge
            // Rising-edge T flip-flop bank and status pulses.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q        <= '0;
                    r_wrap     <= 1'b0;
                    r_load_err <= 1'b0;
                    r_toggles  <= '0;
                end else begin
                    r_q        <= r_q ^ w_toggle_mask;
                    r_wrap     <= w_wrap_next;
                    r_load_err <= w_load_err_next;
                    r_toggles  <= w_toggle_mask;
                end
            end
        end
    endgenerate

    // Terminal count is combinational so a cascaded stage sees it this cycle.
    assign bus.tc       = bus.en & (bus.up ? w_at_last : w_at_zero);
    assign bus.q        = r_q;
    assign bus.wrap     = r_wrap;
    assign bus.load_err = r_load_err;
    assign bus.toggles  = r_toggles;

endmodule
`default_nettype wire

// File: tb/tb_t_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_t_mod_counter
//  Purpose  : Directed self-checking bench for t_mod_counter (falling-edge
//             modulus-10 instance and rising-edge modulus-16 instance).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_t_mod_counter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    t_mod_counter_if #(.WIDTH(4)) bus0 ();
    t_mod_counter_if #(.WIDTH(4)) bus1 ();

    t_mod_counter #(.WIDTH(4), .MODULUS(10), .NEG_EDGE(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    t_mod_counter #(.WIDTH(4), .MODULUS(16), .NEG_EDGE(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // 10 ns clock: rising at 5, 15, ...; falling at 10, 20, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fall_step();
        @(negedge clk);
        #1;
    endtask

    task automatic rise_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] prev_q;
        logic [3:0] exp_q;
        checks   = 0;
        failures = 0;

        rst = 1'b1;
        bus0.en = 1'b0; bus0.up = 1'b1; bus0.load = 1'b0; bus0.din = 4'd0;
        bus1.en = 1'b0; bus1.up = 1'b1; bus1.load = 1'b0; bus1.din = 4'd0;

        // Reset state, before any clock edge
        #2;
        check("rst_q",        bus0.q,        4'd0);
        check("rst_wrap",     bus0.wrap,     1'b0);
        check("rst_load_err", bus0.load_err, 1'b0);
        check("rst_toggles",  bus0.toggles,  4'd0);
        check("rst_q1",       bus1.q,        4'd0);

        fall_step();
        rst = 1'b0;
        bus0.en = 1'b1;
        bus0.up = 1'b1;

        // 1. Count up for 12 falling edges: 1..9,0,1,2
        prev_q = 4'd0;
        for (int i = 0; i < 12; i++) begin
            fall_step();
            exp_q = 4'((i + 1) % 10);
            check($sformatf("up_q_%0d", i),    bus0.q,       exp_q);
            check($sformatf("up_wrap_%0d", i), bus0.wrap,    exp_q == 4'd0);
            check($sformatf("up_tc_%0d", i),   bus0.tc,      exp_q == 4'd9);
            check($sformatf("up_tog_%0d", i),  bus0.toggles, prev_q ^ exp_q);
            prev_q = exp_q;
        end

        // 2. Down from 0 wraps to 9
        bus0.load = 1'b1; bus0.din = 4'd0;
        fall_step();
        check("ld0_q", bus0.q, 4'd0);
        bus0.load = 1'b0; bus0.up = 1'b0;
        fall_step();
        check("dn_q",    bus0.q,       4'd9);
        check("dn_wrap", bus0.wrap,    1'b1);
        check("dn_tog",  bus0.toggles, 4'b1001);
        check("dn_tc",   bus0.tc,      1'b0);
        fall_step();
        check("dn2_q",    bus0.q,       4'd8);
        check("dn2_wrap", bus0.wrap,    1'b0);
        check("dn2_tog",  bus0.toggles, 4'b0001);

        // 3. Loads: in range, then out of range saturates
        bus0.load = 1'b1; bus0.din = 4'd5; bus0.en = 1'b1; bus0.up = 1'b1;
        fall_step();
        check("ld5_q",   bus0.q,        4'd5);
        check("ld5_err", bus0.load_err, 1'b0);
        check("ld5_tog", bus0.toggles,  4'b1101);
        bus0.din = 4'd12;
        fall_step();
        check("ld12_q",    bus0.q,        4'd9);
        check("ld12_err",  bus0.load_err, 1'b1);
        check("ld12_wrap", bus0.wrap,     1'b0);
        check("ld12_tog",  bus0.toggles,  4'b1100);

        // 5. Hold with en=0 at q=9 for 3 edges
        bus0.load = 1'b0; bus0.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fall_step();
            check($sformatf("hold_q_%0d", i),    bus0.q,        4'd9);
            check($sformatf("hold_tc_%0d", i),   bus0.tc,       1'b0);
            check($sformatf("hold_tog_%0d", i),  bus0.toggles,  4'd0);
            check($sformatf("hold_wrap_%0d", i), bus0.wrap,     1'b0);
            check($sformatf("hold_err_%0d", i),  bus0.load_err, 1'b0);
        end

        // 4. Asynchronous reset between edges at q=6
        bus0.load = 1'b1; bus0.din = 4'd6;
        fall_step();
        check("ld6_q",   bus0.q,       4'd6);
        check("ld6_tog", bus0.toggles, 4'b1111);
        bus0.load = 1'b0; bus0.en = 1'b1; bus0.up = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_q",    bus0.q,       4'd0);
        check("arst_wrap", bus0.wrap,    1'b0);
        check("arst_tog",  bus0.toggles, 4'd0);
        rst = 1'b0;
        fall_step();
        check("post_rst_q",   bus0.q,       4'd1);
        check("post_rst_tog", bus0.toggles, 4'b0001);

        // 6. Rising-edge, modulus-16 instance
        bus0.en = 1'b0;
        bus1.load = 1'b1; bus1.din = 4'd14;
        rise_step();
        check("r_ld_q", bus1.q, 4'd14);
        bus1.load = 1'b0; bus1.en = 1'b1; bus1.up = 1'b1;
        fall_step();
        check("r_nofall_q", bus1.q, 4'd14);
        rise_step();
        check("r_q15",  bus1.q,  4'd15);
        check("r_tc15", bus1.tc, 1'b1);
        fall_step();
        check("r_nofall_q15", bus1.q, 4'd15);
        rise_step();
        check("r_wrap_q",   bus1.q,       4'd0);
        check("r_wrap",     bus1.wrap,    1'b1);
        check("r_wrap_tog", bus1.toggles, 4'b1111);
        bus1.up = 1'b0;
        rise_step();
        check("r_dn_q",    bus1.q,    4'd15);
        check("r_dn_wrap", bus1.wrap, 1'b1);
        rise_step();
        check("r_dn2_q",    bus1.q,    4'd14);
        check("r_dn2_wrap", bus1.wrap, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
